// File: rtl/return_fifo_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | return_fifo_if : valid/ready result-token link, producer->consumer |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface return_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] ins;
   logic                  ins_valid;
   logic                  ins_ready;
   logic [DATA_WIDTH-1:0] outs;
   logic                  outs_valid;
   logic                  outs_ready;

   modport master (
      output ins, ins_valid, outs_ready,
      input  ins_ready, outs, outs_valid
   );

   modport slave (
      input  ins, ins_valid, outs_ready,
      output ins_ready, outs, outs_valid
   );
endinterface
`default_nettype wire

// File: rtl/return_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | return_fifo : elastic circular return-value buffer (NUM_SLOTS deep)|
// | Optional 0-latency pass-through when RETURN_FIFO_BYPASS_EN is set.  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module return_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLOTS  = 2
) (
   input  wire logic    clk,
   input  wire logic    rst,
   return_fifo_if.slave bus
);
   localparam int                 c_PTR_W = $clog2(NUM_SLOTS);
   localparam int                 c_CNT_W = $clog2(NUM_SLOTS + 1);
   localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_SLOTS - 1);
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(NUM_SLOTS);

   logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
   logic [c_PTR_W-1:0]    r_head;
   logic [c_PTR_W-1:0]    r_tail;
   logic [c_CNT_W-1:0]    r_count;
   logic [c_CNT_W-1:0]    w_count_nxt;
   logic                  r_ins_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_bypass;

   function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

`ifdef RETURN_FIFO_BYPASS_EN
   // Empty buffer with both sides ready: token goes straight through, nothing stored
   assign w_bypass       = (r_count == '0) & bus.ins_valid & bus.outs_ready;
   assign bus.outs       = w_bypass ? bus.ins : r_mem[r_head];
`else
   assign w_bypass       = 1'b0;
   assign bus.outs       = r_mem[r_head];
`endif

   assign w_push         = bus.ins_valid & r_ins_ready & ~w_bypass;
   assign w_pop          = (r_count != '0) & bus.outs_ready;
   assign bus.ins_ready  = r_ins_ready;
   assign bus.outs_valid = (r_count != '0) | w_bypass;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // ins_ready is precomputed from the next count so it never sees outs_ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_ins_ready <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= bus.ins;
            r_tail        <= next_ptr(r_tail);
         end
         if (w_pop) begin
            r_head <= next_ptr(r_head);
         end
         r_count     <= w_count_nxt;
         r_ins_ready <= (w_count_nxt != c_FULL);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_return_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_return_fifo : randomized scoreboard bench for return_fifo       |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_return_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   return_fifo_if #(.DATA_WIDTH(DW)) bus ();

   return_fifo #(.DATA_WIDTH(DW), .NUM_SLOTS(DEPTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an unbounded queue capped at DEPTH entries
   logic          m_ir, m_ov, m_byp, m_push, m_pop;
   logic [DW-1:0] m_data;
   always @(negedge clk) begin
      if (mon_en) begin
         m_ir  = (exp_q.size() != DEPTH);
         m_byp = 1'b0;
`ifdef RETURN_FIFO_BYPASS_EN
         m_byp = (exp_q.size() == 0) && bus.ins_valid && bus.outs_ready;
`endif
         m_ov  = (exp_q.size() != 0) || m_byp;
         chk("ins_ready", {31'd0, bus.ins_ready}, {31'd0, m_ir});
         chk("outs_valid", {31'd0, bus.outs_valid}, {31'd0, m_ov});
         if (m_ov) begin
            m_data = m_byp ? bus.ins : exp_q[0];
            chk("outs_data", bus.outs, m_data);
         end
         m_push = bus.ins_valid && m_ir;
         m_pop  = m_ov && bus.outs_ready;
         if (m_push) exp_q.push_back(bus.ins);
         if (m_pop)  void'(exp_q.pop_front());
      end
   end

   task automatic send(input logic [DW-1:0] d);
      bit ok = 1'b0;
      bus.ins       = d;
      bus.ins_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = bus.ins_ready;
         @(posedge clk);
         #1;
      end
      bus.ins_valid = 1'b0;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: token %0h not accepted", d);
      end
   endtask

   task automatic drain();
      bus.ins_valid  = 1'b0;
      bus.outs_ready = 1'b1;
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d tokens left, expected 0", exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int cyc;
      bit acc;
      bus.ins        = '0;
      bus.ins_valid  = 1'b0;
      bus.outs_ready = 1'b0;

      // Power-on reset
      @(posedge clk);
      #1;
      chk("rst_ins_ready", {31'd0, bus.ins_ready}, 0);
      chk("rst_outs_valid", {31'd0, bus.outs_valid}, 0);
      chk("rst_outs", bus.outs, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_ins_ready", {31'd0, bus.ins_ready}, 1);
      chk("rel_outs_valid", {31'd0, bus.outs_valid}, 0);
      chk("rel_outs", bus.outs, 0);
      mon_en = 1'b1;

      // Fill to full, hold one more token, then drain in order
      bus.outs_ready = 1'b0;
      send(32'hA);
      send(32'hB);
      send(32'hC);
      chk("full_ins_ready", {31'd0, bus.ins_ready}, 0);
      bus.ins       = 32'hD;
      bus.ins_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("full_hold_ins_ready", {31'd0, bus.ins_ready}, 0);
      chk("full_head", bus.outs, 32'hA);
      bus.outs_ready = 1'b1;
      #1;
      chk("full_pop_ins_ready", {31'd0, bus.ins_ready}, 0);
      send(32'hD);
      drain();

      // Streaming 1..8
      bus.outs_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(DW'(i));
      drain();

      // Simultaneous push and pop at one stored token
      bus.outs_ready = 1'b0;
      send(32'h5);
      bus.outs_ready = 1'b1;
      send(32'h6);
      chk("simul_outs_valid", {31'd0, bus.outs_valid}, 1);
      chk("simul_outs", bus.outs, 32'h6);
      drain();

      // Empty buffer, both sides ready
      bus.ins        = 32'h77;
      bus.ins_valid  = 1'b1;
      bus.outs_ready = 1'b1;
      #1;
`ifdef RETURN_FIFO_BYPASS_EN
      chk("bypass_outs_valid", {31'd0, bus.outs_valid}, 1);
      chk("bypass_outs", bus.outs, 32'h77);
`else
      chk("nobypass_outs_valid", {31'd0, bus.outs_valid}, 0);
`endif
      send(32'h77);
      drain();

      // Random traffic, 50% valid / ready
      sent = 0;
      cyc  = 0;
      bus.ins_valid = 1'b0;
      while (sent < 100 && cyc < 5000) begin
         bus.outs_ready = 1'($urandom_range(0, 1));
         if (!bus.ins_valid && $urandom_range(0, 1) == 1) begin
            bus.ins       = $urandom;
            bus.ins_valid = 1'b1;
         end
         @(negedge clk);
         acc = bus.ins_valid && bus.ins_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            sent++;
            bus.ins_valid = 1'b0;
         end
      end
      checks++;
      if (sent < 100) begin
         errors++;
         $display("FAIL random_timeout: sent %0d expected 100", sent);
      end
      drain();

      // Reset mid-operation with two tokens stored
      bus.outs_ready = 1'b0;
      send(32'h11);
      send(32'h22);
      mon_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("midrst_ins_ready", {31'd0, bus.ins_ready}, 0);
      chk("midrst_outs_valid", {31'd0, bus.outs_valid}, 0);
      chk("midrst_outs", bus.outs, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrel_ins_ready", {31'd0, bus.ins_ready}, 1);
      chk("midrel_outs_valid", {31'd0, bus.outs_valid}, 0);
      chk("midrel_outs", bus.outs, 0);
      mon_en = 1'b1;
      send(32'h33);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/return_fifo.md
Name: return_fifo

Overview:
- Elastic return-value buffer placed directly upstream of the end synchroniser in every dataflow kernel.
- Absorbs the function result token so the producing datapath can retire while the end stage or host is stalled.
- Its registered ins_ready cuts the combinational ready path into the end stage.
- Circular FIFO with NUM_SLOTS entries and a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, width of the result token in bits (>=1).
- NUM_SLOTS, 2, storage depth (>=2, any integer, not limited to powers of two).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset: rst=0 resets immediately; release is synchronous to clk.
- ins  input  DATA_WIDTH  incoming result token.
- ins_valid  input  1  ins holds a valid token.
- ins_ready  output  1  buffer accepts a token this cycle.
- outs  output  DATA_WIDTH  token at the head of the buffer.
- outs_valid  output  1  outs holds a valid token.
- outs_ready  input  1  downstream end stage accepts outs.

Behaviour:
- State:
  - storage array mem[NUM_SLOTS].
  - head pointer and tail pointer, each $clog2(NUM_SLOTS) bits.
  - count, $clog2(NUM_SLOTS+1) bits.
- Reset (rst=0, asynchronous):
  - head=tail=count=0 and every mem entry cleared to 0.
  - While rst=0: ins_ready=0, outs_valid=0, outs=0.
  - First cycle after release: ins_ready=1, outs_valid=0.
- Handshake terms:
  - push = ins_valid & ins_ready.
  - pop = outs_valid & outs_ready.
  - A transfer occurs only on a rising edge where the relevant term is 1.
- ins_ready = (count != NUM_SLOTS). It depends only on registered state, never on outs_ready.
  - When full, ins_ready stays 0 even if a pop occurs in the same cycle.
- outs_valid = (count != 0); outs = mem[head].
  - Once outs_valid=1, outs and outs_valid hold stable until pop.
- push: mem[tail] <= ins; tail advances by 1.
- pop: head advances by 1.
- Pointer wrap: a pointer equal to NUM_SLOTS-1 advances to 0. This is an explicit compare, not modulo power-of-two.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Simultaneous push and pop at count=1: the pop reads the old head and the push writes the tail slot. These are distinct slots, so there is no hazard.
- Latency: 1 cycle minimum. A token accepted at edge N is visible on outs after edge N.
- Throughput: 1 token per cycle in steady state when outs_ready=1.
- Ordering: strict FIFO. No token is dropped or duplicated.
- Boundary values: count never exceeds NUM_SLOTS and never underflows. The pointers stay in [0, NUM_SLOTS-1].
- Reset mid-operation: all stored tokens are discarded. The handshake outputs go to 0 within the same cycle as rst falling.

Optional Feature:
- Macro: RETURN_FIFO_BYPASS_EN.
- Defined: when count=0, ins_valid=1 and outs_ready=1, the incoming token passes straight through.
  - outs = ins and outs_valid = 1, combinationally (0-cycle latency).
  - No write, and the pointers and count do not change.
  - In every other case the behaviour is identical to the default.
  - ins_ready is still !full.
- Undefined: no combinational path from ins or ins_valid to outs or outs_valid. Minimum latency is 1 cycle.

Test Plan:
- Reset check:
  - Stimulus: drop rst mid-cycle with 2 tokens stored.
  - Response: outs_valid=0 and ins_ready=0 immediately.
  - After release: ins_ready=1, outs_valid=0, outs=0.
- Fill, full, drain:
  - Stimulus: NUM_SLOTS=2, outs_ready=0, push 0xA, 0xB, then hold ins_valid=1 with 0xC.
  - Response: ins_ready=0 after the 2nd push.
  - Then set outs_ready=1: outs=0xA, 0xB, 0xC in order, with 0xC accepted only after the first pop.
- Streaming:
  - Stimulus: ins_valid=outs_ready=1 continuously with tokens 1..8.
  - Response: outs delivers 1..8, one per cycle, 1-cycle latency, count oscillating between 0 and 1.
- Wrap with non-power-of-two depth:
  - Stimulus: NUM_SLOTS=3, random ins_valid and outs_ready (50%), 100 tokens.
  - Response: the scoreboard matches exact order.
  - Pointers wrap 2->0, and count stays within 0..3.
- Simultaneous push and pop at count=1:
  - Stimulus: stored 0x5, push 0x6 while popping.
  - Response: count stays 1, next outs=0x6.
- Bypass (with RETURN_FIFO_BYPASS_EN):
  - Stimulus: empty buffer, ins=0x77, ins_valid=1, outs_ready=1.
  - Response: outs=0x77 and outs_valid=1 in the same cycle, count stays 0.
  - Without the macro: outs_valid rises one cycle later.
